// File: rtl/breakout_pkg.sv
// Shared game-control types: FSM state encoding and USB HID key codes.
// The PAUSE state exists only when PAUSE_KEY_EN is defined.
package breakout_pkg;

  typedef enum logic [2:0] {
    StAttract = 3'd0,
    StServe   = 3'd1,
    StPlay    = 3'd2,
    StMiss    = 3'd3,
    StOver    = 3'd4,
    StWin     = 3'd5
`ifdef PAUSE_KEY_EN
    ,
    StPause   = 3'd6
`endif
  } state_e;

  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

endpackage

// File: rtl/frame_timer.sv
// 8-bit loadable down-counter that stops at zero and flags it.
module frame_timer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [7:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 8'd0)) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 8'd0);

endmodule

// File: rtl/game_ctrl.sv
// Breakout game-flow controller: attract/serve/play/miss/over/win sequencing, one step per frame.
// Define PAUSE_KEY_EN to add a SPACE-toggled PAUSE state reachable from PLAY.
module game_ctrl
  import breakout_pkg::*;
#(
  parameter int unsigned LIVES        = 3,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned MISS_FRAMES  = 30
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       Ball_Lost,
  input  logic       Bricks_Cleared,
  output logic       Bar_Reset,
  output logic       Ball_Reset,
  output logic       Ball_Launch,
  output logic       Freeze,
  output logic [2:0] Lives,
  output logic [2:0] Game_State
);

  localparam logic [2:0] LivesInit = 3'(LIVES);
  localparam logic [7:0] ServeLoad = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] MissLoad  = 8'(MISS_FRAMES - 1);

  state_e     state_d, state_q;
  logic [2:0] lives_d, lives_q;
  logic [7:0] key_prev_q;
  logic       bar_d, bar_q, ball_d, ball_q, launch_d, launch_q, freeze_d, freeze_q;
  logic       tmr_load, tmr_dec, tmr_zero;
  logic [7:0] tmr_val;
  logic       enter_edge;

  assign enter_edge = (keycode == KEY_ENTER) && (key_prev_q != KEY_ENTER);
`ifdef PAUSE_KEY_EN
  logic space_edge;
  assign space_edge = (keycode == KEY_SPACE) && (key_prev_q != KEY_SPACE);
`endif

  frame_timer u_timer (
    .clk_i      (frame_clk),
    .rst_i      (Reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  // Timer runs only while waiting out a serve or a lost ball; PAUSE holds it.
  assign tmr_dec = (state_q == StServe) || (state_q == StMiss);

  always_comb begin
    state_d  = state_q;
    lives_d  = lives_q;
    tmr_load = 1'b0;
    tmr_val  = ServeLoad;
    launch_d = 1'b0;
    case (state_q)
      StAttract, StOver, StWin: begin
        if (enter_edge) begin
          state_d  = StServe;
          lives_d  = LivesInit;
          tmr_load = 1'b1;
        end
      end
      StServe: begin
        if (tmr_zero) begin
          state_d  = StPlay;
          launch_d = 1'b1;
        end
      end
      StPlay: begin
        if (Bricks_Cleared) begin
          state_d = StWin;
        end else if (Ball_Lost) begin
          state_d  = StMiss;
          lives_d  = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
          tmr_load = 1'b1;
          tmr_val  = MissLoad;
        end
`ifdef PAUSE_KEY_EN
        else if (space_edge) begin
          state_d = StPause;
        end
`endif
      end
      StMiss: begin
        if (tmr_zero) begin
          if (lives_q == 3'd0) begin
            state_d = StOver;
          end else begin
            state_d  = StServe;
            tmr_load = 1'b1;
          end
        end
      end
`ifdef PAUSE_KEY_EN
      StPause: begin
        if (space_edge) begin
          state_d = StPlay;
        end
      end
`endif
      default: state_d = StAttract;
    endcase
  end

  // Level outputs are decoded from the next state so they register alongside it.
  always_comb begin
    bar_d    = (state_d == StAttract) || (state_d == StServe);
    ball_d   = (state_d != StPlay);
    freeze_d = (state_d == StMiss) || (state_d == StOver) || (state_d == StWin);
`ifdef PAUSE_KEY_EN
    ball_d   = ball_d && (state_d != StPause);
    freeze_d = freeze_d || (state_d == StPause);
`endif
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= StAttract;
      lives_q    <= LivesInit;
      key_prev_q <= 8'd0;
      bar_q      <= 1'b1;
      ball_q     <= 1'b1;
      launch_q   <= 1'b0;
      freeze_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lives_q    <= lives_d;
      key_prev_q <= keycode;
      bar_q      <= bar_d;
      ball_q     <= ball_d;
      launch_q   <= launch_d;
      freeze_q   <= freeze_d;
    end
  end

  assign Bar_Reset   = bar_q;
  assign Ball_Reset  = ball_q;
  assign Ball_Launch = launch_q;
  assign Freeze      = freeze_q;
  assign Lives       = lives_q;
  assign Game_State  = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed scoreboard bench for game_ctrl with default parameters (3 lives, 60 serve, 30 miss).
module tb_game_ctrl;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode;
  logic       Ball_Lost, Bricks_Cleared;
  logic       Bar_Reset, Ball_Reset, Ball_Launch, Freeze;
  logic [2:0] Lives, Game_State;

  localparam logic [7:0] KeyEnter = 8'h28;
  localparam logic [7:0] KeySpace = 8'h2C;

  game_ctrl dut (
    .frame_clk      (frame_clk),
    .Reset          (Reset),
    .keycode        (keycode),
    .Ball_Lost      (Ball_Lost),
    .Bricks_Cleared (Bricks_Cleared),
    .Bar_Reset      (Bar_Reset),
    .Ball_Reset     (Ball_Reset),
    .Ball_Launch    (Ball_Launch),
    .Freeze         (Freeze),
    .Lives          (Lives),
    .Game_State     (Game_State)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] lives;
    logic       bar;
    logic       ball;
    logic       launch;
    logic       freeze;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    vectors     = 0;
  int    miscompares = 0;

  function automatic exp_t mk(logic [2:0] st, logic [2:0] lv, logic bar, logic ball,
                              logic launch, logic freeze);
    exp_t e;
    e.st = st; e.lives = lv; e.bar = bar; e.ball = ball; e.launch = launch; e.freeze = freeze;
    return e;
  endfunction

  function automatic exp_t e_att(logic [2:0] lv);   return mk(3'd0, lv, 1, 1, 0, 0); endfunction
  function automatic exp_t e_serve(logic [2:0] lv); return mk(3'd1, lv, 1, 1, 0, 0); endfunction
  function automatic exp_t e_play(logic [2:0] lv, logic l); return mk(3'd2, lv, 0, 0, l, 0);
  endfunction
  function automatic exp_t e_miss(logic [2:0] lv);  return mk(3'd3, lv, 0, 1, 0, 1); endfunction
  function automatic exp_t e_over();                return mk(3'd4, 3'd0, 0, 1, 0, 1); endfunction
  function automatic exp_t e_win(logic [2:0] lv);   return mk(3'd5, lv, 0, 1, 0, 1); endfunction

  task automatic push(input string t, input exp_t e);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic check_now();
    exp_t  e, o;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = {Game_State, Lives, Bar_Reset, Ball_Reset, Ball_Launch, Freeze};
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: got st=%0d lives=%0d bar=%b ball=%b launch=%b freeze=%b, want st=%0d lives=%0d bar=%b ball=%b launch=%b freeze=%b",
             t, o.st, o.lives, o.bar, o.ball, o.launch, o.freeze,
             e.st, e.lives, e.bar, e.ball, e.launch, e.freeze);
    end
  endtask

  task automatic step(input string t, input exp_t e);
    push(t, e);
    @(posedge frame_clk);
    @(negedge frame_clk);
    check_now();
  endtask

  // Caller has already stepped the SERVE entry frame; keycode is released after 5 held frames.
  task automatic serve_phase(input logic [2:0] lv);
    for (int i = 1; i < 60; i++) begin
      if (i == 5) keycode = 8'd0;
      Ball_Lost      = (i == 10);
      Bricks_Cleared = (i == 20);
      step("serve_wait", e_serve(lv));
    end
    Ball_Lost      = 1'b0;
    Bricks_Cleared = 1'b0;
    step("launch", e_play(lv, 1'b1));
    step("launch_done", e_play(lv, 1'b0));
  endtask

  task automatic miss_phase(input logic [2:0] lv);
    for (int i = 1; i < 30; i++) begin
      Ball_Lost = (i == 7);
      step("miss_wait", e_miss(lv));
    end
    Ball_Lost = 1'b0;
  endtask

  initial begin
    Reset          = 1'b1;
    keycode        = 8'd0;
    Ball_Lost      = 1'b0;
    Bricks_Cleared = 1'b0;
    @(negedge frame_clk);
    push("reset_state", e_att(3'd3));
    check_now();
    Reset = 1'b0;

    Ball_Lost = 1'b1;
    step("attract_ignore_lost", e_att(3'd3));
    Ball_Lost = 1'b0;

    keycode = KeyEnter;
    step("enter_serve", e_serve(3'd3));
    serve_phase(3'd3);
    step("play_idle", e_play(3'd3, 1'b0));

`ifdef PAUSE_KEY_EN
    keycode = KeySpace;
    step("pause_enter", mk(3'd6, 3'd3, 0, 0, 0, 1));
    keycode   = 8'd0;
    Ball_Lost = 1'b1;
    step("pause_ignore_lost", mk(3'd6, 3'd3, 0, 0, 0, 1));
    Ball_Lost = 1'b0;
    keycode   = KeySpace;
    step("pause_exit", e_play(3'd3, 1'b0));
    keycode = 8'd0;
`else
    keycode = KeySpace;
    step("space_nop", e_play(3'd3, 1'b0));
    step("space_held_nop", e_play(3'd3, 1'b0));
    keycode = 8'd0;
`endif

    Ball_Lost = 1'b1;
    step("miss1", e_miss(3'd2));
    Ball_Lost = 1'b0;
    miss_phase(3'd2);
    step("reserve2", e_serve(3'd2));
    serve_phase(3'd2);

    Ball_Lost = 1'b1;
    step("miss2", e_miss(3'd1));
    Ball_Lost = 1'b0;
    miss_phase(3'd1);
    step("reserve3", e_serve(3'd1));
    serve_phase(3'd1);

    Ball_Lost = 1'b1;
    step("miss3", e_miss(3'd0));
    Ball_Lost = 1'b0;
    miss_phase(3'd0);
    step("game_over", e_over());
    Ball_Lost = 1'b1;
    step("over_ignore_lost", e_over());
    Ball_Lost = 1'b0;
    step("over_hold", e_over());

    keycode = KeyEnter;
    step("restart", e_serve(3'd3));
    serve_phase(3'd3);
    Bricks_Cleared = 1'b1;
    Ball_Lost      = 1'b1;
    step("win_priority", e_win(3'd3));
    Bricks_Cleared = 1'b0;
    Ball_Lost      = 1'b0;
    step("win_hold", e_win(3'd3));

    keycode = KeyEnter;
    step("win_restart", e_serve(3'd3));
    for (int i = 1; i < 40; i++) begin
      if (i == 5) keycode = 8'd0;
      step("serve_pre_reset", e_serve(3'd3));
    end
    // Timer now at 20; reset must take effect without a clock edge.
    #2 Reset = 1'b1;
    #1;
    push("async_reset", e_att(3'd3));
    check_now();
    @(negedge frame_clk);
    Reset = 1'b0;
    for (int i = 0; i < 70; i++) begin
      step("post_reset_no_launch", e_att(3'd3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
